ftdi_fifo_arbiter: RTL and testbench
====================================

# ftdi_fifo_arbiter

Sequences the FT245-style asynchronous FIFO bus of the FTDI bridge (8-bit bidirectional ADBUS plus RXF/TXE/RD/WR) and shares it between the host-to-FPGA read path and the FPGA-to-host write path. It sits between the chip-level pin mapping and the LaserDrop datapath. It owns the ADBUS tristate enable and generates all RD/WR strobe timing. It presents a valid/ready byte stream in each direction.

## Interface
- RD_PULSE, 3: cycles ftdi_rd held low; adbus_in sampled on last edge.
- WR_SETUP, 1: cycles data driven before ftdi_wr falls.
- WR_PULSE, 3: cycles ftdi_wr held low.
- RECOVER, 3: idle cycles after each strobe; must be ≥3 (elaboration error otherwise).
- clock  in  1  50 MHz system clock.
- reset_n  in  1  Reset: synchronous, active-low.
- en  in  1  Enables new bus transactions.
- rxf  in  1  FTDI RXF#, active-low, asynchronous; low = byte available.
- txe  in  1  FTDI TXE#, active-low, asynchronous; low = space available.
- adbus_in  in  8  ADBUS pin values.
- adbus_out  out  8  ADBUS drive value.
- adbus_tri  out  1  1 = FPGA drives ADBUS.
- ftdi_rd  out  1  RD#, active-low.
- ftdi_wr  out  1  WR#, active-low.
- rx_data  out  8  Byte read from host.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  Downstream accepts rx_data.
- tx_data  in  8  Byte to send to host.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  Block accepts tx_data.
- busy  out  1  State ≠ IDLE.

## Operation
- rxf and txe pass through 2-flop synchronizers → rxf_s, txe_s.
- One-entry RX holding register:
  - rx_valid set when a read completes.
  - Cleared on rx_valid & rx_ready.
- One-entry TX holding register:
  - Loaded on tx_valid & tx_ready.
  - tx_ready = ~tx_full (registered).
- Requests:
  - rd_req = en & ~rxf_s & ~rx_valid.
  - wr_req = en & ~txe_s & tx_full.
- Arbitration happens only in IDLE. With both requests: round-robin on the last_grant bit (see Configuration).
- FSM states: IDLE, RD_STROBE, RD_RECOVER, WR_SETUP, WR_STROBE, WR_RECOVER. A down-counter times each state.
  - IDLE → RD_STROBE: ftdi_rd=0 for RD_PULSE cycles. On the final edge, adbus_in is captured into rx_data and rx_valid=1.
  - RD_STROBE → RD_RECOVER: ftdi_rd=1 for RECOVER cycles, then IDLE.
  - IDLE → WR_SETUP: adbus_tri=1 and adbus_out=tx byte, held WR_SETUP cycles.
  - WR_SETUP → WR_STROBE: ftdi_wr=0 for WR_PULSE cycles.
  - WR_STROBE → WR_RECOVER: ftdi_wr=1. adbus_tri stays 1 for the first recover cycle only, then 0. tx_full is cleared on entry. After RECOVER cycles, IDLE.
- Invariants:
  - adbus_tri=1 never coincides with ftdi_rd=0.
  - ftdi_rd and ftdi_wr are never low together.
  - All pin outputs are registered.
- en low: no new grant. An in-flight transaction completes. Holding registers keep their contents.

## Timing
- Reset values (while reset_n=0 at an edge):
  - ftdi_rd=1, ftdi_wr=1, adbus_tri=0, adbus_out=0.
  - rx_data=0, rx_valid=0, tx_ready=0, busy=0.
  - State IDLE, last_grant=write.
  - tx_ready rises on the first edge after release.
- Reset mid-transaction: strobes return high and adbus_tri=0 on the next edge. The byte is dropped and both holding registers are cleared.
- Latencies:
  - rxf falling → ftdi_rd low: 3 cycles (2 sync + grant).
  - Read: ftdi_rd low RD_PULSE cycles; rx_valid rises the same edge ftdi_rd rises.
  - Write: total bus occupancy is WR_SETUP+WR_PULSE+RECOVER cycles.
- RECOVER ≥3 covers synchronizer staleness, so a stale rxf/txe never re-triggers a transaction.
- Back-to-back reads: period RD_PULSE+RECOVER+1 = 7 cycles at defaults, provided rx_ready is held high.
- Read/write turnaround:
  - FPGA drives ≥RECOVER cycles after ftdi_rd rises.
  - FPGA releases one cycle after ftdi_wr rises.

## Configuration
- FTDI_ROUND_ROBIN_EN defined: when rd_req and wr_req are both high in IDLE, grant the direction not granted last; last_grant updates on each grant.
- FTDI_ROUND_ROBIN_EN undefined: fixed priority, read wins. last_grant is not implemented.

## Structure
- ftdi_pkg holds:
  - The FSM state enum typedef.
  - The default timing localparams (RD_PULSE, WR_SETUP, WR_PULSE, RECOVER).
  - The grant-direction enum.
- One sub-module, ftdi_sync: parameterised-width 2-flop synchronizer, instantiated for rxf/txe.

## Test plan
- Reset check: hold reset_n=0 with rxf=0. All outputs hold reset values; the first ftdi_rd low appears 3 cycles after release.
- Single read: rxf=0, adbus_in=8'hA5, rx_ready=0.
  - ftdi_rd low exactly 3 cycles, then rx_data=A5 and rx_valid=1.
  - No second read until rx_ready pulses.
- Single write: txe=0, push tx_data=8'h3C.
  - adbus_tri=1 with adbus_out=3C for 1 cycle before ftdi_wr falls.
  - ftdi_wr low 3 cycles; adbus_tri drops 1 cycle after ftdi_wr rises.
- Contention: rxf=0, txe=0, tx_valid held with bytes 01,02, rx_ready=1.
  - With the macro defined: grants alternate R,W,R,W.
  - Without it: reads only while rxf=0.
  - Assert ftdi_rd=0 never coincides with adbus_tri=1.
- Mid-write reset: reset_n=0 during WR_STROBE. The next edge gives ftdi_wr=1, adbus_tri=0, tx_ready=0, busy=0.
- en toggle: en=0 with rxf=0 gives no strobe. en dropped during RD_STROBE still completes the read.

Source files
------------

// File: rtl/ftdi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ftdi_pkg
// Description : Shared types and default timing for the FT245-style FIFO bus
//               arbiter: FSM state encoding, grant direction, default strobe
//               and recovery lengths (in clock cycles), and a small helper
//               used to size the shared state-timing counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ftdi_pkg;

  // Default bus timing, in system clock cycles.
  localparam int DEF_RD_PULSE = 3;  // ftdi_rd low time; data sampled on last edge
  localparam int DEF_WR_SETUP = 1;  // data driven before ftdi_wr falls
  localparam int DEF_WR_PULSE = 3;  // ftdi_wr low time
  localparam int DEF_RECOVER  = 3;  // idle time after every strobe

  // Recovery must outlast the 2-flop synchronizer plus one cycle so that an
  // rxf/txe level that has not yet caught up with the FTDI side is never
  // mistaken for a fresh request.
  localparam int MIN_RECOVER  = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_STROBE  = 3'd1,
    ST_RD_RECOVER = 3'd2,
    ST_WR_SETUP   = 3'd3,
    ST_WR_STROBE  = 3'd4,
    ST_WR_RECOVER = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ftdi_sync.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_sync
// Description : Parameterised-width two-flop synchronizer for asynchronous
//               level inputs (FTDI RXF#/TXE#).
// Ports       : clock      - system clock
//               reset_n    - synchronous active-low reset
//               d[W-1:0]   - asynchronous input levels
//               q[W-1:0]   - synchronized levels (2 cycles latency)
// Parameters  : WIDTH      - number of bits
//               RESET_VAL  - value both stages take during reset
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/ftdi_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_fifo_arbiter
// Description : Sequences the FT245-style asynchronous FIFO bus (8-bit
//               bidirectional ADBUS, RXF#/TXE#/RD#/WR#) and shares it between
//               the host-to-FPGA read path and FPGA-to-host write path. Owns
//               the ADBUS tristate enable and all strobe timing; presents a
//               valid/ready byte stream in each direction through one-entry
//               holding registers.
// Ports       : clock, reset_n      - system clock, sync active-low reset
//               en                  - allow new bus transactions
//               rxf, txe            - FTDI RXF#/TXE# (async, active-low)
//               adbus_in/out/tri    - ADBUS pins; tri=1 means FPGA drives
//               ftdi_rd, ftdi_wr    - RD#/WR# strobes, active-low
//               rx_data/valid/ready - host-to-FPGA byte stream
//               tx_data/valid/ready - FPGA-to-host byte stream
//               busy                - FSM not idle
// Config      : FTDI_ROUND_ROBIN_EN - when defined, simultaneous read/write
//               requests alternate direction; otherwise read always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_fifo_arbiter
  import ftdi_pkg::*;
#(
  parameter int RD_PULSE = DEF_RD_PULSE,
  parameter int WR_SETUP = DEF_WR_SETUP,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int RECOVER  = DEF_RECOVER
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic       rxf,
  input  logic       txe,
  input  logic [7:0] adbus_in,
  output logic [7:0] adbus_out,
  output logic       adbus_tri,
  output logic       ftdi_rd,
  output logic       ftdi_wr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  // Counter holds (phase length - 1), so it needs to represent the longest
  // phase length minus one.
  localparam int MAX_PHASE = max4(RD_PULSE, WR_SETUP, WR_PULSE, RECOVER);
  localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  generate
    if (RECOVER < MIN_RECOVER) begin : g_bad_recover
      $error("ftdi_fifo_arbiter: RECOVER must be at least 3 cycles");
    end
    if ((RD_PULSE < 1) || (WR_SETUP < 1) || (WR_PULSE < 1)) begin : g_bad_pulse
      $error("ftdi_fifo_arbiter: strobe and setup lengths must be at least 1 cycle");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Synchronizers. Reset to 1 (inactive) so nothing is requested until the
  // real pin levels have propagated through both stages.
  // --------------------------------------------------------------------------
  logic rxf_s;
  logic txe_s;

  ftdi_sync #(
    .WIDTH     (2),
    .RESET_VAL (2'b11)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       ({rxf, txe}),
    .q       ({rxf_s, txe_s})
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ftdi_rd_q, ftdi_rd_d;
  logic             ftdi_wr_q, ftdi_wr_d;
  logic             adbus_tri_q, adbus_tri_d;
  logic [7:0]       adbus_out_q, adbus_out_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       tx_hold_q, tx_hold_d;
  logic             tx_full_q, tx_full_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;

  logic rd_req;
  logic wr_req;
  logic grant_rd;
  logic grant_wr;

  assign rd_req = en & ~rxf_s & ~rx_valid_q;
  assign wr_req = en & ~txe_s & tx_full_q;

  // --------------------------------------------------------------------------
  // Arbitration (only consumed in IDLE)
  // --------------------------------------------------------------------------
`ifdef FTDI_ROUND_ROBIN_EN
  grant_t last_grant_q, last_grant_d;

  always_comb begin
    grant_rd = rd_req;
    grant_wr = wr_req;
    if (rd_req && wr_req) begin
      grant_rd = (last_grant_q == GRANT_WR);
      grant_wr = (last_grant_q == GRANT_RD);
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE) begin
      if (grant_rd) begin
        last_grant_d = GRANT_RD;
      end else if (grant_wr) begin
        last_grant_d = GRANT_WR;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_WR;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    grant_rd = rd_req;
    grant_wr = wr_req & ~rd_req;
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ftdi_rd_d   = ftdi_rd_q;
    ftdi_wr_d   = ftdi_wr_q;
    adbus_tri_d = adbus_tri_q;
    adbus_out_d = adbus_out_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    tx_hold_d   = tx_hold_q;
    tx_full_d   = tx_full_q;

    // Stream-side handshakes. A TX load can only happen while the holding
    // register is empty, so it never races the clear in WR_STROBE below.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (tx_valid && tx_ready_q) begin
      tx_full_d = 1'b1;
      tx_hold_d = tx_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          state_d   = ST_RD_STROBE;
          ftdi_rd_d = 1'b0;
          cnt_d     = CNT_W'(RD_PULSE - 1);
        end else if (grant_wr) begin
          state_d     = ST_WR_SETUP;
          adbus_tri_d = 1'b1;
          adbus_out_d = tx_hold_q;
          cnt_d       = CNT_W'(WR_SETUP - 1);
        end
      end

      ST_RD_STROBE: begin
        if (cnt_q == '0) begin
          // Final strobe edge: capture the bus as RD# returns high.
          state_d    = ST_RD_RECOVER;
          ftdi_rd_d  = 1'b1;
          rx_data_d  = adbus_in;
          rx_valid_d = 1'b1;
          cnt_d      = CNT_W'(RECOVER - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RD_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WR_SETUP: begin
        if (cnt_q == '0) begin
          state_d   = ST_WR_STROBE;
          ftdi_wr_d = 1'b0;
          cnt_d     = CNT_W'(WR_PULSE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WR_STROBE: begin
        if (cnt_q == '0) begin
          // Data stays driven through the first recover cycle for hold time.
          state_d   = ST_WR_RECOVER;
          ftdi_wr_d = 1'b1;
          tx_full_d = 1'b0;
          cnt_d     = CNT_W'(RECOVER - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WR_RECOVER: begin
        adbus_tri_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        ftdi_rd_d   = 1'b1;
        ftdi_wr_d   = 1'b1;
        adbus_tri_d = 1'b0;
      end
    endcase

    tx_ready_d = ~tx_full_d;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ftdi_rd_q   <= 1'b1;
      ftdi_wr_q   <= 1'b1;
      adbus_tri_q <= 1'b0;
      adbus_out_q <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_hold_q   <= 8'h00;
      tx_full_q   <= 1'b0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ftdi_rd_q   <= ftdi_rd_d;
      ftdi_wr_q   <= ftdi_wr_d;
      adbus_tri_q <= adbus_tri_d;
      adbus_out_q <= adbus_out_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign adbus_out = adbus_out_q;
  assign adbus_tri = adbus_tri_q;
  assign ftdi_rd   = ftdi_rd_q;
  assign ftdi_wr   = ftdi_wr_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ftdi_fifo_arbiter
// Description : Self-checking bench for ftdi_fifo_arbiter. Stimulus pushes
//               expected grants / read bytes / written bytes into queues; a
//               negedge monitor pops and compares whenever the DUT starts a
//               strobe or presents rx data. Directed timing checks are made
//               from the stimulus thread.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_fifo_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en;
  logic       rxf;
  logic       txe;
  logic [7:0] adbus_in;
  logic [7:0] adbus_out;
  logic       adbus_tri;
  logic       ftdi_rd;
  logic       ftdi_wr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  ftdi_fifo_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .rxf       (rxf),
    .txe       (txe),
    .adbus_in  (adbus_in),
    .adbus_out (adbus_out),
    .adbus_tri (adbus_tri),
    .ftdi_rd   (ftdi_rd),
    .ftdi_wr   (ftdi_wr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  always #10 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] exp_grant_q[$];  // "R" or "W" in grant order
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];

  int   grant_cnt = 0;
  int   inv_viol  = 0;
  logic mon_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    logic prev_rd, prev_wr, prev_tri, prev_rv;
    logic [7:0] e;
    prev_rd = 1'b1; prev_wr = 1'b1; prev_tri = 1'b0; prev_rv = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if ((adbus_tri === 1'b1 && ftdi_rd === 1'b0) || (ftdi_rd === 1'b0 && ftdi_wr === 1'b0))
          inv_viol++;
        if (prev_rd === 1'b1 && ftdi_rd === 1'b0) begin
          grant_cnt++;
          chk("read_grant_expected", 32'(exp_grant_q.size() != 0), 32'd1);
          if (exp_grant_q.size() != 0) begin
            e = exp_grant_q.pop_front();
            chk("grant_dir_read", 32'("R"), 32'(e));
          end
        end
        if (prev_tri === 1'b0 && adbus_tri === 1'b1) begin
          grant_cnt++;
          chk("write_grant_expected", 32'(exp_grant_q.size() != 0), 32'd1);
          if (exp_grant_q.size() != 0) begin
            e = exp_grant_q.pop_front();
            chk("grant_dir_write", 32'("W"), 32'(e));
          end
        end
        if (prev_wr === 1'b1 && ftdi_wr === 1'b0) begin
          chk("tx_byte_expected", 32'(exp_tx_q.size() != 0), 32'd1);
          if (exp_tx_q.size() != 0) begin
            e = exp_tx_q.pop_front();
            chk("wr_bus_data", {23'd0, adbus_tri, adbus_out}, {23'd0, 1'b1, e});
          end
        end
        if (prev_rv === 1'b0 && rx_valid === 1'b1) begin
          chk("rx_byte_expected", 32'(exp_rx_q.size() != 0), 32'd1);
          if (exp_rx_q.size() != 0) begin
            e = exp_rx_q.pop_front();
            chk("rx_data", {24'd0, rx_data}, {24'd0, e});
          end
        end
      end
      prev_rd = ftdi_rd; prev_wr = ftdi_wr; prev_tri = adbus_tri; prev_rv = rx_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk("tx_accept", 32'(n < 100), 32'd1);
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic count_low_rd(output int lo);
    lo = 1;
    while (ftdi_rd === 1'b0 && lo < 20) begin
      step(1);
      if (ftdi_rd === 1'b0) lo++;
    end
  endtask

  initial begin
    int n, lo, cnt, base;

    reset_n  = 1'b0;
    en       = 1'b1;
    rxf      = 1'b0;
    txe      = 1'b1;
    adbus_in = 8'hA5;
    rx_ready = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    // ---- reset values and read latency after release ----
    step(3);
    chk("reset_outputs",
        {8'd0, ftdi_rd, ftdi_wr, adbus_tri, adbus_out, rx_data, rx_valid, tx_ready, busy},
        {8'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
    mon_en = 1'b1;
    exp_grant_q.push_back("R");
    exp_rx_q.push_back(8'hA5);
    reset_n = 1'b1;
    step(1);
    chk("tx_ready_after_release", 32'(tx_ready), 32'd1);
    n = 1;
    while (ftdi_rd !== 1'b0 && n < 10) begin
      step(1);
      n++;
    end
    chk("rd_latency", n, 3);

    // ---- single read ----
    count_low_rd(lo);
    chk("rd_low_cycles", lo, 3);
    chk("rx_valid_at_rd_rise", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'hA5});
    cnt = 0;
    repeat (20) begin
      step(1);
      if (ftdi_rd === 1'b0) cnt++;
    end
    chk("no_read_while_rx_full", cnt, 0);
    rxf = 1'b1;
    step(4);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("rx_valid_cleared", 32'(rx_valid), 32'd0);

    // ---- single write ----
    txe = 1'b0;
    step(3);
    exp_grant_q.push_back("W");
    exp_tx_q.push_back(8'h3C);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    chk("tx_ready_when_full", 32'(tx_ready), 32'd0);
    n = 0;
    while (adbus_tri !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("wr_grant_latency", n, 1);
    n = 0;
    while (adbus_tri === 1'b1 && ftdi_wr === 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("wr_setup_cycles", n, 1);
    chk("wr_data_during_strobe", {24'd0, adbus_out}, 32'h3C);
    lo = 1;
    while (ftdi_wr === 1'b0 && lo < 20) begin
      step(1);
      if (ftdi_wr === 1'b0) lo++;
    end
    chk("wr_low_cycles", lo, 3);
    chk("tri_held_at_wr_rise", {30'd0, adbus_tri, tx_ready}, {30'd0, 1'b1, 1'b1});
    step(1);
    chk("tri_released", 32'(adbus_tri), 32'd0);
    txe = 1'b1;
    step(8);

    // ---- contention ----
    adbus_in = 8'h5A;
    base     = grant_cnt;
`ifdef FTDI_ROUND_ROBIN_EN
    exp_grant_q.push_back("R"); exp_grant_q.push_back("W");
    exp_grant_q.push_back("R"); exp_grant_q.push_back("W");
    exp_rx_q.push_back(8'h5A); exp_rx_q.push_back(8'h5A);
    exp_tx_q.push_back(8'h01); exp_tx_q.push_back(8'h02);
`else
    repeat (4) begin
      exp_grant_q.push_back("R");
      exp_rx_q.push_back(8'h5A);
    end
`endif
    rxf      = 1'b0;
    txe      = 1'b0;
    rx_ready = 1'b1;
    fork
      begin
        send_byte(8'h01);
`ifdef FTDI_ROUND_ROBIN_EN
        send_byte(8'h02);
`endif
      end
      begin
        n = 0;
        while (grant_cnt < base + 4 && n < 200) begin
          step(1);
          n++;
        end
        chk("contention_grants_seen", 32'(n < 200), 32'd1);
        en = 1'b0;
      end
    join
    rxf = 1'b1;
    txe = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      step(1);
      n++;
    end
    step(10);
    chk("contention_grant_total", grant_cnt - base, 4);

    // ---- reset during WR_STROBE ----
`ifdef FTDI_ROUND_ROBIN_EN
    exp_grant_q.push_back("W");
    exp_tx_q.push_back(8'h77);
    send_byte(8'h77);
`else
    exp_grant_q.push_back("W");
    exp_tx_q.push_back(8'h01);  // still pending from contention
`endif
    txe = 1'b0;
    en  = 1'b1;
    n = 0;
    while (ftdi_wr !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk("midwrite_strobe_seen", 32'(ftdi_wr), 32'd0);
    step(1);
    reset_n = 1'b0;
    step(1);
    chk("midwrite_reset_outputs",
        {27'd0, ftdi_wr, ftdi_rd, adbus_tri, tx_ready, busy},
        {27'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    reset_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      step(1);
      if (busy === 1'b1) cnt++;
    end
    chk("byte_dropped_after_reset", cnt, 0);
    chk("tx_ready_after_reset", 32'(tx_ready), 32'd1);

    // ---- en gating ----
    txe      = 1'b1;
    en       = 1'b0;
    rxf      = 1'b0;
    rx_ready = 1'b0;
    adbus_in = 8'hC3;
    cnt = 0;
    repeat (10) begin
      step(1);
      if (ftdi_rd === 1'b0) cnt++;
    end
    chk("no_strobe_en_low", cnt, 0);
    exp_grant_q.push_back("R");
    exp_rx_q.push_back(8'hC3);
    en = 1'b1;
    n = 0;
    while (ftdi_rd !== 1'b0 && n < 10) begin
      step(1);
      n++;
    end
    chk("en_read_started", 32'(ftdi_rd), 32'd0);
    en = 1'b0;
    count_low_rd(lo);
    chk("en_drop_read_completes", lo, 3);
    chk("en_drop_rx_data", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'hC3});
    cnt = 0;
    repeat (15) begin
      step(1);
      if (ftdi_rd === 1'b0) cnt++;
    end
    chk("no_new_grant_en_low", cnt, 0);
    chk("rx_hold_kept", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'hC3});

    // ---- final scoreboard state ----
    step(2);
    chk("grant_queue_drained", exp_grant_q.size(), 0);
    chk("rx_queue_drained", exp_rx_q.size(), 0);
    chk("tx_queue_drained", exp_tx_q.size(), 0);
    chk("bus_invariant_violations", inv_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
